// File: rtl/branch_seq.sv
// Branch-instruction control sequencer: steps through T3..T6 to conditionally load PC from Z.
// Optional feature macro: BRANCH_SEQ_SKIP_EN (an untaken branch jumps from T3 straight to FIN).
module branch_seq (
  input  logic        clock,
  input  logic        clear,
  input  logic        start,
  input  logic        hold,
  input  logic [31:0] IR,
  input  logic [31:0] bus,
  output logic        Gra,
  output logic        Rout,
  output logic        CONin,
  output logic        PCout,
  output logic        Yin,
  output logic        Cout,
  output logic        ADD,
  output logic        Zin,
  output logic        Zlowout,
  output logic        PCin,
  output logic        CON,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    T3   = 3'd1,
    T4   = 3'd2,
    T5   = 3'd3,
    T6   = 3'd4,
    FIN  = 3'd5
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic        r_con;
  logic        w_cond;
  logic [1:0]  w_condCode;
  logic        w_busZero;
  logic        w_busNeg;
  logic        w_unusedIr;

  assign w_condCode = IR[20:19];
  assign w_unusedIr = ^{IR[31:21], IR[18:0]};
  assign w_busZero  = (bus == 32'd0);
  assign w_busNeg   = bus[31];

  // Branch condition on the signed bus value; "greater than" excludes zero.
  always_comb begin
    w_cond = 1'b0;
    case (w_condCode)
      2'b00:   w_cond = w_busZero;
      2'b01:   w_cond = !w_busZero;
      2'b10:   w_cond = !w_busNeg && !w_busZero;
      2'b11:   w_cond = w_busNeg;
      default: w_cond = 1'b0;
    endcase
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      r_state <= IDLE;
    end else if (!hold) begin
      r_state <= w_next;
    end
  end

  // CON is captured only on a non-stalled exit from T3 and then held.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      r_con <= 1'b0;
    end else if (!hold && (r_state == T3)) begin
      r_con <= w_cond;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_next = T3;
        end
      end
      T3: begin
`ifdef BRANCH_SEQ_SKIP_EN
        w_next = w_cond ? T4 : FIN;
`else
        w_next = T4;
`endif
      end
      T4:      w_next = T5;
      T5:      w_next = T6;
      T6:      w_next = FIN;
      FIN:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Moore strobes: each state owns at most one bus driver.
  always_comb begin
    Gra     = 1'b0;
    Rout    = 1'b0;
    CONin   = 1'b0;
    PCout   = 1'b0;
    Yin     = 1'b0;
    Cout    = 1'b0;
    ADD     = 1'b0;
    Zin     = 1'b0;
    Zlowout = 1'b0;
    PCin    = 1'b0;
    busy    = 1'b1;
    done    = 1'b0;
    case (r_state)
      IDLE: busy = 1'b0;
      T3: begin
        Gra   = 1'b1;
        Rout  = 1'b1;
        CONin = 1'b1;
      end
      T4: begin
        PCout = 1'b1;
        Yin   = 1'b1;
      end
      T5: begin
        Cout = 1'b1;
        ADD  = 1'b1;
        Zin  = 1'b1;
      end
      T6: begin
        Zlowout = 1'b1;
        PCin    = r_con;
      end
      FIN:     done = 1'b1;
      default: busy = 1'b0;
    endcase
  end

  assign CON = r_con;

endmodule
